jtsdram_bankchk: RTL

//  Parametrised per-bank SDRAM traffic generator/checker, one instance per SDRAM bank port.

---
 rtl/jtsdram_bankchk.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/jtsdram_bankchk.sv
// ---------------------------------------------------------------------------
// jtsdram_bankchk
//   Per-bank SDRAM traffic generator and checker. One instance sits on one
//   SDRAM bank port. A pass walks 2^AW word addresses starting at 0, stepping
//   by `stride` (0 behaves as 1). Each access is a read, or a write when `we`
//   is set and the LFSR picks one. Every completed read is compared against
//   `data_ref` and mismatches are counted in a saturating error counter.
//   Pacing between accesses is either frame-synchronised (issue only while
//   LVBL is high) or LFSR-randomised (0..15 extra cycles, LVBL ignored).
//
//   Optional feature: define JTSDRAM_FAILLOG_EN to capture the address and
//   read data of the first mismatch after reset/clr. When the macro is not
//   defined, fail_addr/fail_data are tied to 0 and no capture logic exists.
//
// Parameters
//   AW    bank address width (words)
//   DW    compared data width
//   EW    error counter width (saturating)
//   SEED  LFSR reset value, must be non-zero
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   LVBL       vertical blank (low during blank); paces non-slow issue
//   start      1-cycle pulse: begin a pass at address 0 (aborts a running one)
//   clr        1-cycle pulse: clear bad, err_cnt and the fail log
//   slow       1: random gap between accesses, LVBL ignored
//   we         1: writes allowed, picked randomly per access
//   stride     address increment, 0 treated as 1
//   data_ref   expected data for the current address
//   ack        controller accepted the request
//   rdy        access completed, data_read valid this cycle
//   data_read  read data
//   addr       access address
//   rd / wr    read / write request, held until ack (never both high)
//   busy       pass in progress
//   done       pass complete, held until the next start
//   bad        sticky mismatch flag
//   err_cnt    saturating mismatch count
//   fail_addr  address of the first mismatch
//   fail_data  read data of the first mismatch
// ---------------------------------------------------------------------------
module jtsdram_bankchk #(
    parameter int          AW   = 22,
    parameter int          DW   = 16,
    parameter int          EW   = 16,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    input  logic          start,
    input  logic          clr,
    input  logic          slow,
    input  logic          we,
    input  logic [AW-1:0] stride,
    input  logic [DW-1:0] data_ref,
    input  logic          ack,
    input  logic          rdy,
    input  logic [DW-1:0] data_read,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic          wr,
    output logic          busy,
    output logic          done,
    output logic          bad,
    output logic [EW-1:0] err_cnt,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, GAP, DONE} state_t;

    state_t        state, state_nx;
    logic [15:0]   lfsr;
    logic          lfsr_fb;
    logic [AW-1:0] cnt;
    logic [AW-1:0] step;
    logic [3:0]    gap;
    logic          wrtng;     // current access is a write
    logic          pend;      // an accepted access has not completed yet
    logic          skip;      // next rdy belongs to an aborted access
    logic          begin_pass;
    logic          abort;
    logic          acc_done;
    logic          last_acc;
    logic          wr_pick;
    logic          mismatch;

    // Fibonacci LFSR, taps 16,14,13,11
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign wr_pick    = we & lfsr[0];
    assign step       = (stride == '0) ? AW'(1) : stride;
    assign last_acc   = &cnt;
    assign begin_pass = start && (state == IDLE || state == DONE);
    assign abort      = start && busy;
    // A start in WAIT aborts, so its rdy must not count as a completion.
    assign acc_done   = (state == WAIT) && rdy && !skip && !start;
    assign mismatch   = acc_done && !wrtng && (data_read != data_ref);

    always_comb begin
        // NOTE: always_comb assigns a default first so no path can infer a latch.
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = REQ;
            REQ:        state_nx = WAIT;
            WAIT: begin
                if (acc_done) begin
                    if (last_acc)           state_nx = DONE;
                    else if (!slow && LVBL) state_nx = REQ;
                    else                    state_nx = GAP;
                end
            end
            GAP:     if (slow ? (gap == 4'd0) : LVBL) state_nx = REQ;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = REQ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lfsr  <= SEED;
            addr  <= '0;
            cnt   <= '0;
            gap   <= '0;
            rd    <= 1'b0;
            wr    <= 1'b0;
            wrtng <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pend  <= 1'b0;
            skip  <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
            state <= state_nx;
            lfsr  <= {lfsr[14:0], lfsr_fb};

            if (rdy)                    pend <= 1'b0;
            else if (ack && (rd || wr)) pend <= 1'b1;

            if (rdy) skip <= 1'b0;

            if (begin_pass || abort) begin
                addr <= '0;
                cnt  <= '0;
                busy <= 1'b1;
                done <= 1'b0;
                rd   <= 1'b0;
                wr   <= 1'b0;
                // An access already accepted by the controller will still
                // complete later; remember to discard that rdy.
                if (abort && !rdy && (pend || (ack && (rd || wr))))
                    skip <= 1'b1;
            end else begin
                case (state)
                    REQ: begin
                        rd    <= !wr_pick;
                        wr    <= wr_pick;
                        wrtng <= wr_pick;
                    end
                    WAIT: begin
                        if (ack || acc_done) begin
                            rd <= 1'b0;
                            wr <= 1'b0;
                        end
                        if (acc_done) begin
                            addr <= addr + step;
                            cnt  <= cnt + AW'(1);
                            gap  <= lfsr[3:0];
                            if (last_acc) begin
                                busy <= 1'b0;
                                done <= 1'b1;
                            end
                        end
                    end
                    GAP: if (gap != 4'd0) gap <= gap - 4'd1;
                    default: ;
                endcase
            end
        end
    end

    // Error accounting: clr has priority over a same-cycle mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad     <= 1'b0;
            err_cnt <= '0;
        end else if (clr) begin
            bad     <= 1'b0;
            err_cnt <= '0;
        end else if (mismatch) begin
            bad <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + EW'(1);
        end
    end

`ifdef JTSDRAM_FAILLOG_EN
    // bad is still low exactly when no mismatch has been seen since reset/clr,
    // so it doubles as the "first mismatch" qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_addr <= '0;
            fail_data <= '0;
        end else if (clr) begin
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mismatch && !bad) begin
            fail_addr <= addr;
            fail_data <= data_read;
        end
    end
`else
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

endmodule
